// File: rtl/dram_chip.sv
// Behavioural x4 DDR4-style DRAM device: 16 banks, each with its own FSM and timer.
// Data lives per bank / row[3:0] / column and is returned combinationally on dq during reads.
module dram_chip #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 17,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int TRCD         = 4,
  parameter int TRP          = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              halt,
  input  logic [18:0]                       commands,
  input  logic [BGWIDTH:0]                  bg,
  input  logic [BAWIDTH:0]                  ba,
  inout  wire  [DEVICE_WIDTH-1:0]           dq,
  inout  wire                               dqs_c,
  inout  wire                               dqs_t,
  input  logic [ADDRWIDTH-1:0]              row,
  input  logic [$clog2(COLWIDTH**2)-1:0]    column
);

  localparam int BANKGROUPS    = BGWIDTH ** 2;
  localparam int BANKSPERGROUP = BAWIDTH ** 2;
  localparam int NBANKS        = BANKGROUPS * BANKSPERGROUP;
  localparam int BANKW         = BGWIDTH + BAWIDTH;
  localparam int COLS          = COLWIDTH ** 2;
  localparam int TW            = 8;

  localparam int C_ACT = 18;
  localparam int C_PR  = 7;
  localparam int C_PRA = 6;
  localparam int C_RD  = 5;
  localparam int C_RDA = 4;
  localparam int C_WR  = 1;
  localparam int C_WRA = 0;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ACTIVATING  = 3'd1;
  localparam logic [2:0] ST_ACTIVE      = 3'd2;
  localparam logic [2:0] ST_WRITING     = 3'd3;
  localparam logic [2:0] ST_READING     = 3'd4;
  localparam logic [2:0] ST_PRECHARGING = 3'd5;

  if (BL < 1 || TRCD < 1 || TRP < 1) begin : g_bad_param
    $error("dram_chip: BL, TRCD and TRP must all be at least 1");
  end

  logic [2:0]              r_state    [NBANKS];
  logic [TW-1:0]           r_timer    [NBANKS];
  logic                    r_auto     [NBANKS];
  logic [3:0]              r_open_row [NBANKS];
  logic [DEVICE_WIDTH-1:0] r_mem      [NBANKS][16][COLS];

  logic [2:0]              w_state_nxt [NBANKS];
  logic [TW-1:0]           w_timer_nxt [NBANKS];
  logic                    w_auto_nxt  [NBANKS];
  logic [3:0]              w_row_nxt   [NBANKS];

  logic [BANKW-1:0]        w_bank;
  logic                    w_legal;
  logic                    w_act, w_pr, w_pra, w_rd_cmd, w_rda, w_wr_cmd, w_wra;
  logic                    w_sel;
  logic [2:0]              w_cur_state;
  logic                    w_open;
  logic                    w_col_ok;
  logic                    w_rd_drive;
  logic                    w_wr_en;
  logic [DEVICE_WIDTH-1:0] w_rd_data;
  logic                    w_unused;

  assign w_bank   = {bg[BGWIDTH-1:0], ba[BAWIDTH-1:0]};
  // Anything other than exactly one asserted bit (or any command under halt) is dropped.
  assign w_legal  = ($countones(commands) == 1) && !halt;
  assign w_act    = w_legal && commands[C_ACT];
  assign w_pr     = w_legal && commands[C_PR];
  assign w_pra    = w_legal && commands[C_PRA];
  assign w_rd_cmd = w_legal && commands[C_RD];
  assign w_rda    = w_legal && commands[C_RDA];
  assign w_wr_cmd = w_legal && commands[C_WR];
  assign w_wra    = w_legal && commands[C_WRA];

  assign w_cur_state = r_state[w_bank];
  assign w_open      = (w_cur_state == ST_ACTIVE) || (w_cur_state == ST_WRITING) ||
                       (w_cur_state == ST_READING);
  assign w_col_ok    = int'(column) < COLS;
  assign w_rd_drive  = w_open && (w_rd_cmd || w_rda);
  assign w_wr_en     = w_open && (w_wr_cmd || w_wra) && w_col_ok && !reset_n;
  assign w_rd_data   = w_col_ok ? r_mem[w_bank][r_open_row[w_bank]][column] : '0;

  assign dq    = w_rd_drive ? w_rd_data : {DEVICE_WIDTH{1'bz}};
  assign dqs_t = w_rd_drive ? 1'b1 : 1'bz;
  assign dqs_c = w_rd_drive ? 1'b0 : 1'bz;

  assign w_unused = ^{bg[BGWIDTH], ba[BAWIDTH], row[ADDRWIDTH-1:4]};

  always_comb begin
    w_sel = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      w_state_nxt[b] = r_state[b];
      w_timer_nxt[b] = r_timer[b];
      w_auto_nxt[b]  = r_auto[b];
      w_row_nxt[b]   = r_open_row[b];
      w_sel          = (w_bank == BANKW'(b));
      if (!halt) begin
        case (r_state[b])
          ST_IDLE: begin
            if (w_sel && w_act) begin
              w_state_nxt[b] = ST_ACTIVATING;
              w_timer_nxt[b] = TW'(TRCD - 1);
              w_row_nxt[b]   = row[3:0];
            end
          end
          ST_ACTIVATING: begin
            if (r_timer[b] == '0) w_state_nxt[b] = ST_ACTIVE;
            else                  w_timer_nxt[b] = r_timer[b] - TW'(1);
          end
          ST_ACTIVE, ST_WRITING, ST_READING: begin
            if ((w_sel && w_pr) || w_pra) begin
              w_state_nxt[b] = ST_PRECHARGING;
              w_timer_nxt[b] = TW'(TRP - 1);
              w_auto_nxt[b]  = 1'b0;
            end else if (w_sel && (w_wr_cmd || w_wra)) begin
              w_state_nxt[b] = ST_WRITING;
              w_auto_nxt[b]  = w_wra;
            end else if (w_sel && (w_rd_cmd || w_rda)) begin
              w_state_nxt[b] = ST_READING;
              w_auto_nxt[b]  = w_rda;
            end else if (r_state[b] != ST_ACTIVE) begin
              // Burst ended: auto-precharge variants close the row, plain ones leave it open.
              w_state_nxt[b] = r_auto[b] ? ST_PRECHARGING : ST_ACTIVE;
              w_timer_nxt[b] = r_auto[b] ? TW'(TRP - 1) : r_timer[b];
              w_auto_nxt[b]  = 1'b0;
            end
          end
          ST_PRECHARGING: begin
            if (r_timer[b] == '0) w_state_nxt[b] = ST_IDLE;
            else                  w_timer_nxt[b] = r_timer[b] - TW'(1);
          end
          default: w_state_nxt[b] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int b = 0; b < NBANKS; b++) begin
        r_state[b]    <= ST_IDLE;
        r_timer[b]    <= '0;
        r_auto[b]     <= 1'b0;
        r_open_row[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        r_state[b]    <= w_state_nxt[b];
        r_timer[b]    <= w_timer_nxt[b];
        r_auto[b]     <= w_auto_nxt[b];
        r_open_row[b] <= w_row_nxt[b];
      end
    end
  end

  // Storage is not reset; writes land on the same edge that samples the WR command.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_bank][r_open_row[w_bank]][column] <= dq;
  end

endmodule

// File: tb/tb_dram_chip.sv
// Directed bench for dram_chip: bank FSM timing, halt, write/read data path, illegal commands.
module tb_dram_chip;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt;
  logic [18:0] commands;
  logic [2:0]  bg;
  logic [2:0]  ba;
  logic [16:0] row;
  logic [6:0]  column;
  logic [3:0]  tb_dq;
  logic        tb_dq_oe;
  wire  [3:0]  dq;
  wire         dqs_c;
  wire         dqs_t;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [18:0] ACT = 19'h40000;
  localparam logic [18:0] PR  = 19'h00080;
  localparam logic [18:0] PRA = 19'h00040;
  localparam logic [18:0] RD  = 19'h00020;
  localparam logic [18:0] WR  = 19'h00002;
  localparam logic [18:0] WRA = 19'h00001;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACTV = 3'd1;
  localparam logic [2:0] S_ACT  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_PRE  = 3'd5;

  assign dq = tb_dq_oe ? tb_dq : 4'bz;

  dram_chip dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .halt     (halt),
    .commands (commands),
    .bg       (bg),
    .ba       (ba),
    .dq       (dq),
    .dqs_c    (dqs_c),
    .dqs_t    (dqs_t),
    .row      (row),
    .column   (column)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b1; halt = 1'b0; commands = '0; bg = '0; ba = '0; row = '0; column = '0;
    tb_dq = '0; tb_dq_oe = 1'b0;
    tick;
    reset_n = 1'b0;
    repeat (5) tick;
    for (int b = 0; b < 16; b++) begin
      n_checks++;
      if (dut.r_state[b] !== S_IDLE)
        $display("FAIL reset_state bank %0d: got %0d want %0d", b, dut.r_state[b], S_IDLE);
      else n_pass++;
    end
    n_checks++;
    if (dut.w_rd_drive !== 1'b0) $display("FAIL reset_dq_release: got %b want 0", dut.w_rd_drive);
    else n_pass++;
  endtask

  task automatic test_activate;
    commands = ACT; bg = 3'd0; ba = 3'd0; row = 17'd0;
    tick;
    commands = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dut.r_state[0] !== S_ACTV)
        $display("FAIL act_wait cycle %0d: got %0d want %0d", k, dut.r_state[0], S_ACTV);
      else n_pass++;
      tick;
    end
    n_checks++;
    if (dut.r_state[0] !== S_ACT) $display("FAIL act_done: got %0d want %0d", dut.r_state[0], S_ACT);
    else n_pass++;
    n_checks++;
    if (dut.r_state[1] !== S_IDLE || dut.r_state[15] !== S_IDLE)
      $display("FAIL act_others: got %0d/%0d want %0d", dut.r_state[1], dut.r_state[15], S_IDLE);
    else n_pass++;
  endtask

  task automatic test_halt;
    commands = ACT; bg = 3'd1; ba = 3'd1; row = 17'd3;
    tick;
    commands = '0;
    tick;
    // RD to the open bank 0 during the halt must neither drive dq nor move its FSM.
    halt = 1'b1; commands = RD; bg = 3'd0; ba = 3'd0; column = 7'd1;
    repeat (3) tick;
    n_checks++;
    if (dut.r_state[5] !== S_ACTV) $display("FAIL halt_frozen: got %0d want %0d", dut.r_state[5], S_ACTV);
    else n_pass++;
    n_checks++;
    if (dut.r_state[0] !== S_ACT) $display("FAIL halt_cmd_ignored: got %0d want %0d", dut.r_state[0], S_ACT);
    else n_pass++;
    n_checks++;
    if (dut.w_rd_drive !== 1'b0) $display("FAIL halt_dq_release: got %b want 0", dut.w_rd_drive);
    else n_pass++;
    halt = 1'b0; commands = '0; bg = 3'd1; ba = 3'd1;
    tick;
    tick;
    n_checks++;
    if (dut.r_state[5] !== S_ACTV) $display("FAIL halt_resume_wait: got %0d want %0d", dut.r_state[5], S_ACTV);
    else n_pass++;
    tick;
    n_checks++;
    if (dut.r_state[5] !== S_ACT) $display("FAIL halt_resume_done: got %0d want %0d", dut.r_state[5], S_ACT);
    else n_pass++;
    halt = 1'b1; commands = PR;
    repeat (4) tick;
    n_checks++;
    if (dut.r_state[5] !== S_ACT) $display("FAIL halt_active_hold: got %0d want %0d", dut.r_state[5], S_ACT);
    else n_pass++;
    halt = 1'b0; commands = '0;
  endtask

  task automatic test_write_read;
    logic [6:0] cols [6];
    logic [3:0] dat  [6];
    cols = '{7'd1, 7'd4, 7'd7, 7'd0, 7'd3, 7'd6};
    dat  = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7};
    bg = 3'd0; ba = 3'd0; tb_dq_oe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      commands = WR; column = cols[i]; tb_dq = dat[i];
      tick;
      n_checks++;
      if (dut.r_state[0] !== S_WR) $display("FAIL wr_state %0d: got %0d want %0d", i, dut.r_state[0], S_WR);
      else n_pass++;
    end
    commands = WR; column = 7'd100; tb_dq = 4'hf;
    tick;
    tb_dq_oe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      commands = RD; column = cols[i];
      #1;
      n_checks++;
      if (dq !== dat[i]) $display("FAIL rd_data col %0d: got %h want %h", cols[i], dq, dat[i]);
      else n_pass++;
      n_checks++;
      if (dqs_t !== 1'b1 || dqs_c !== 1'b0)
        $display("FAIL rd_strobe col %0d: got t=%b c=%b want t=1 c=0", cols[i], dqs_t, dqs_c);
      else n_pass++;
      tick;
    end
    n_checks++;
    if (dut.r_state[0] !== S_RD) $display("FAIL rd_state: got %0d want %0d", dut.r_state[0], S_RD);
    else n_pass++;
    commands = RD; column = 7'd100;
    #1;
    n_checks++;
    if (dq !== 4'h0) $display("FAIL rd_col_out_of_range: got %h want 0", dq);
    else n_pass++;
    tick;
    commands = '0;
    tick;
    n_checks++;
    if (dut.r_state[0] !== S_ACT) $display("FAIL rd_end_state: got %0d want %0d", dut.r_state[0], S_ACT);
    else n_pass++;
    n_checks++;
    if (dut.w_rd_drive !== 1'b0) $display("FAIL rd_end_release: got %b want 0", dut.w_rd_drive);
    else n_pass++;
  endtask

  task automatic test_auto_precharge;
    bg = 3'd1; ba = 3'd1; commands = WRA; column = 7'd2; tb_dq = 4'd9; tb_dq_oe = 1'b1;
    tick;
    n_checks++;
    if (dut.r_state[5] !== S_WR) $display("FAIL wra_state: got %0d want %0d", dut.r_state[5], S_WR);
    else n_pass++;
    commands = '0; tb_dq_oe = 1'b0;
    tick;
    n_checks++;
    if (dut.r_state[5] !== S_PRE) $display("FAIL wra_precharge: got %0d want %0d", dut.r_state[5], S_PRE);
    else n_pass++;
    repeat (4) tick;
    n_checks++;
    if (dut.r_state[5] !== S_IDLE) $display("FAIL wra_idle: got %0d want %0d", dut.r_state[5], S_IDLE);
    else n_pass++;
    // Row 19 aliases onto row 3 where the WRA data went.
    commands = ACT; row = 17'd19;
    tick;
    commands = '0;
    repeat (4) tick;
    n_checks++;
    if (dut.r_state[5] !== S_ACT) $display("FAIL alias_act: got %0d want %0d", dut.r_state[5], S_ACT);
    else n_pass++;
    commands = RD; column = 7'd2;
    #1;
    n_checks++;
    if (dq !== 4'd9) $display("FAIL alias_rd: got %h want 9", dq);
    else n_pass++;
    tick;
    commands = '0;
    tick;
  endtask

  task automatic test_precharge;
    bg = 3'd0; ba = 3'd0; commands = PR;
    tick;
    commands = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dut.r_state[0] !== S_PRE)
        $display("FAIL pre_wait cycle %0d: got %0d want %0d", k, dut.r_state[0], S_PRE);
      else n_pass++;
      tick;
    end
    n_checks++;
    if (dut.r_state[0] !== S_IDLE) $display("FAIL pre_idle: got %0d want %0d", dut.r_state[0], S_IDLE);
    else n_pass++;
    commands = RD; column = 7'd1;
    #1;
    n_checks++;
    if (dut.w_rd_drive !== 1'b0) $display("FAIL idle_rd_drive: got %b want 0", dut.w_rd_drive);
    else n_pass++;
    tick;
    n_checks++;
    if (dut.r_state[0] !== S_IDLE) $display("FAIL idle_rd_state: got %0d want %0d", dut.r_state[0], S_IDLE);
    else n_pass++;
    commands = '0;
  endtask

  task automatic test_illegal;
    bg = 3'd1; ba = 3'd1; commands = ACT; row = 17'd0;
    tick;
    n_checks++;
    if (dut.r_state[5] !== S_ACT) $display("FAIL act_on_active: got %0d want %0d", dut.r_state[5], S_ACT);
    else n_pass++;
    commands = RD; column = 7'd2;
    #1;
    n_checks++;
    if (dq !== 4'd9) $display("FAIL act_on_active_row: got %h want 9", dq);
    else n_pass++;
    tick;
    commands = RD | WR;
    #1;
    n_checks++;
    if (dut.w_rd_drive !== 1'b0) $display("FAIL two_hot_drive: got %b want 0", dut.w_rd_drive);
    else n_pass++;
    tick;
    n_checks++;
    if (dut.r_state[5] !== S_ACT) $display("FAIL two_hot_state: got %0d want %0d", dut.r_state[5], S_ACT);
    else n_pass++;
    bg = 3'd0; ba = 3'd0; commands = ACT | RD;
    tick;
    n_checks++;
    if (dut.r_state[0] !== S_IDLE) $display("FAIL two_hot_act: got %0d want %0d", dut.r_state[0], S_IDLE);
    else n_pass++;
    commands = 19'h00400;
    tick;
    n_checks++;
    if (dut.r_state[0] !== S_IDLE) $display("FAIL reserved_bit: got %0d want %0d", dut.r_state[0], S_IDLE);
    else n_pass++;
    commands = '0;
  endtask

  task automatic test_pra;
    bg = 3'd0; ba = 3'd0; commands = PRA;
    tick;
    commands = '0;
    n_checks++;
    if (dut.r_state[5] !== S_PRE || dut.r_state[0] !== S_IDLE)
      $display("FAIL pra: got %0d/%0d want %0d/%0d", dut.r_state[5], dut.r_state[0], S_PRE, S_IDLE);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_activate;
    test_halt;
    test_write_read;
    test_auto_precharge;
    test_precharge;
    test_illegal;
    test_pra;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
